// File: rtl/pe_array_feeder_pkg.sv
// Shared types and defaults for the PE array feeder.
// Holds the sequencer state encoding and the drain-length helper.
package pe_array_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_NUMBER_PE_ROW = 9;
  localparam int DEF_NUMBER_PE_COL = 8;
  localparam int DEF_VEC_COUNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_W_STROBE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Cycles needed for the last skewed vector to leave the far corner of the array.
  function automatic int drain_len(input int rows, input int cols);
    return rows - 1 + cols;
  endfunction

endpackage

// File: rtl/pe_array_feeder_skew_delay_line.sv
// Fixed-depth shift register carrying {valid,data} for one skew lane.
// A synchronous clear empties every stage.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH:0] stage_q [DEPTH];
  logic [WIDTH:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = {i_vld, i_data};
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign {o_vld, o_data} = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_array_feeder.sv
// Job sequencer for the systolic PE array: loads weights, streams skewed
// feature-map vectors into the left edge, drains the array and flags completion.
module pe_array_feeder
  import pe_array_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUMBER_PE_ROW = DEF_NUMBER_PE_ROW,
  parameter int NUMBER_PE_COL = DEF_NUMBER_PE_COL,
  parameter int VEC_COUNT_W   = DEF_VEC_COUNT_W
) (
  input  logic                                          i_clk,
  input  logic                                          i_rest,
  input  logic                                          i_start,
  input  logic [VEC_COUNT_W-1:0]                        i_num_vec,
  input  logic                                          i_w_valid,
  input  logic [DATA_WIDTH*NUMBER_PE_ROW-1:0]           i_w_data,
  output logic                                          o_w_ready,
  input  logic                                          i_f_valid,
  input  logic [DATA_WIDTH*NUMBER_PE_ROW-1:0]           i_f_data,
  output logic                                          o_f_ready,
  output logic [DATA_WIDTH*NUMBER_PE_ROW*NUMBER_PE_COL-1:0] o_weight_col,
  output logic                                          o_weight_en,
  output logic [DATA_WIDTH*NUMBER_PE_ROW-1:0]           o_fmap,
  output logic [NUMBER_PE_ROW-1:0]                      o_fmap_vld,
  output logic                                          o_busy,
  output logic                                          o_done
);

  localparam int COLW = DATA_WIDTH * NUMBER_PE_ROW;
  localparam int WALL = COLW * NUMBER_PE_COL;
  localparam int D    = drain_len(NUMBER_PE_ROW, NUMBER_PE_COL);
  localparam int CW   = (NUMBER_PE_COL > 1) ? $clog2(NUMBER_PE_COL) : 1;
  localparam int DNW  = $clog2(D + 1);

  localparam logic [CW-1:0]  COL_LAST   = CW'(NUMBER_PE_COL - 1);
  localparam logic [DNW-1:0] DRAIN_LAST = DNW'(D - 1);

  state_e                 state_q, state_d;
  logic [VEC_COUNT_W-1:0] num_vec_q, num_vec_d;
  logic [VEC_COUNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CW-1:0]          col_cnt_q, col_cnt_d;
  logic [DNW-1:0]         drain_cnt_q, drain_cnt_d;
  logic [WALL-1:0]        weight_q, weight_d;

  logic            w_hs, f_hs;
  logic [COLW-1:0] lane_data;

  assign w_hs = i_w_valid & o_w_ready;
  assign f_hs = i_f_valid & o_f_ready;

  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      state_q     <= ST_IDLE;
      num_vec_q   <= '0;
      vec_cnt_q   <= '0;
      col_cnt_q   <= '0;
      drain_cnt_q <= '0;
      weight_q    <= '0;
    end else begin
      state_q     <= state_d;
      num_vec_q   <= num_vec_d;
      vec_cnt_q   <= vec_cnt_d;
      col_cnt_q   <= col_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      weight_q    <= weight_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_vec_d   = num_vec_q;
    vec_cnt_d   = vec_cnt_q;
    col_cnt_d   = col_cnt_q;
    drain_cnt_d = drain_cnt_q;
    weight_d    = weight_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          num_vec_d = i_num_vec;
          col_cnt_d = '0;
          state_d   = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (w_hs) begin
          weight_d[col_cnt_q*COLW +: COLW] = i_w_data;
          if (col_cnt_q == COL_LAST) begin
            col_cnt_d = '0;
            state_d   = ST_W_STROBE;
          end else begin
            col_cnt_d = col_cnt_q + CW'(1);
          end
        end
      end
      ST_W_STROBE: begin
        vec_cnt_d = '0;
        state_d   = (num_vec_q != '0) ? ST_STREAM : ST_DONE;
      end
      ST_STREAM: begin
        if (f_hs) begin
          if (vec_cnt_q == num_vec_q - VEC_COUNT_W'(1)) begin
            drain_cnt_d = DRAIN_LAST;
            state_d     = ST_DRAIN;
          end else begin
            vec_cnt_d = vec_cnt_q + VEC_COUNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - DNW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_w_ready   = (state_q == ST_LOAD_W);
    o_f_ready   = (state_q == ST_STREAM) && (vec_cnt_q < num_vec_q);
    o_weight_en = (state_q == ST_W_STROBE);
    o_busy      = (state_q != ST_IDLE);
    o_done      = (state_q == ST_DONE);
  end

  assign o_weight_col = weight_q;

  // Idle cycles push zero bubbles so gaps in the input stream survive the skew.
  assign lane_data = f_hs ? i_f_data : '0;

  for (genvar r = 0; r < NUMBER_PE_ROW; r++) begin : g_lane
    skew_delay_line #(
      .DEPTH (r + 1),
      .WIDTH (DATA_WIDTH)
    ) u_skew (
      .i_clk  (i_clk),
      .i_clr  (i_rest),
      .i_vld  (f_hs),
      .i_data (lane_data[r*DATA_WIDTH +: DATA_WIDTH]),
      .o_vld  (o_fmap_vld[r]),
      .o_data (o_fmap[r*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Scoreboard bench for pe_array_feeder: stimulus pushes expected array-side
// events with their due cycle, a negedge monitor matches what the DUT presents.
module tb_pe_array_feeder;

  localparam int DW   = 32;
  localparam int ROW  = 9;
  localparam int COL  = 8;
  localparam int VW   = 16;
  localparam int D    = 16;
  localparam int CWID = DW * ROW;
  localparam int WALL = CWID * COL;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_start;
  logic [VW-1:0]   i_num_vec;
  logic            i_w_valid;
  logic [CWID-1:0] i_w_data;
  logic            o_w_ready;
  logic            i_f_valid;
  logic [CWID-1:0] i_f_data;
  logic            o_f_ready;
  logic [WALL-1:0] o_weight_col;
  logic            o_weight_en;
  logic [CWID-1:0] o_fmap;
  logic [ROW-1:0]  o_fmap_vld;
  logic            o_busy;
  logic            o_done;

  always #5 clk = ~clk;

  pe_array_feeder dut (
    .i_clk        (clk),
    .i_rest       (rst),
    .i_start      (i_start),
    .i_num_vec    (i_num_vec),
    .i_w_valid    (i_w_valid),
    .i_w_data     (i_w_data),
    .o_w_ready    (o_w_ready),
    .i_f_valid    (i_f_valid),
    .i_f_data     (i_f_data),
    .o_f_ready    (o_f_ready),
    .o_weight_col (o_weight_col),
    .o_weight_en  (o_weight_en),
    .o_fmap       (o_fmap),
    .o_fmap_vld   (o_fmap_vld),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    int          row;
    logic [DW-1:0] data;
  } fexp_t;

  fexp_t           fq[$];
  int              wq_cyc[$];
  logic [WALL-1:0] wq_dat[$];
  int              dq[$];

  task automatic chk(input string nm, input logic [WALL-1:0] got, input logic [WALL-1:0] exp);
    int k;
    k = 0;
    checks++;
    if (got !== exp) begin
      errors++;
      for (int i = 0; i < WALL/DW; i++) begin
        if (got[i*DW +: DW] !== exp[i*DW +: DW]) begin
          k = i;
          break;
        end
      end
      $display("FAIL %s cyc=%0d word%0d got=%h required=%h", nm, cyc, k, got[k*DW +: DW], exp[k*DW +: DW]);
    end
  endtask

  task automatic fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d", msg, cyc);
  endtask

  function automatic logic [CWID-1:0] wcol(input logic [31:0] base, input int step, input int c);
    logic [CWID-1:0] v;
    for (int r = 0; r < ROW; r++) v[r*DW +: DW] = base + 32'(c) + 32'(r * step);
    return v;
  endfunction

  function automatic logic [CWID-1:0] fvec(input logic [31:0] base, input int step, input int n);
    logic [CWID-1:0] v;
    for (int r = 0; r < ROW; r++) v[r*DW +: DW] = base + 32'(n * 256) + 32'(r * step);
    return v;
  endfunction

  // Monitor
  int fi;
  always @(negedge clk) begin
    if (!rst) begin
      for (int r = 0; r < ROW; r++) begin
        if (o_fmap_vld[r]) begin
          fi = -1;
          for (int i = 0; i < fq.size(); i++) begin
            if (fq[i].row == r && fq[i].cyc == cyc) begin
              fi = i;
              break;
            end
          end
          if (fi < 0) begin
            checks++;
            errors++;
            $display("FAIL fmap_unexpected row=%0d cyc=%0d got=%h required=no_valid", r, cyc, o_fmap[r*DW +: DW]);
          end else begin
            chk($sformatf("fmap_row%0d", r), WALL'(o_fmap[r*DW +: DW]), WALL'(fq[fi].data));
            fq.delete(fi);
          end
        end
      end
      for (int i = fq.size() - 1; i >= 0; i--) begin
        if (fq[i].cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL fmap_missing row=%0d cyc=%0d got=no_valid required=%h", fq[i].row, cyc, fq[i].data);
          fq.delete(i);
        end
      end
      if (o_weight_en) begin
        if (wq_cyc.size() > 0 && wq_cyc[0] == cyc) begin
          chk("weight_col_at_strobe", o_weight_col, wq_dat[0]);
          void'(wq_cyc.pop_front());
          void'(wq_dat.pop_front());
        end else begin
          fail("weight_en_unexpected got=1 required=0");
        end
      end else if (wq_cyc.size() > 0 && wq_cyc[0] <= cyc) begin
        fail("weight_en_missing got=0 required=1");
        void'(wq_cyc.pop_front());
        void'(wq_dat.pop_front());
      end
      if (o_done) begin
        checks++;
        if (dq.size() > 0 && dq[0] == cyc) begin
          void'(dq.pop_front());
        end else begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d got=1 required=0", cyc);
        end
      end else if (dq.size() > 0 && dq[0] <= cyc) begin
        fail("done_missing got=0 required=1");
        void'(dq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) tick();
    @(negedge clk);
  endtask

  task automatic start_job(input int n);
    tick();
    i_start   = 1'b1;
    i_num_vec = VW'(n);
    tick();
    i_start   = 1'b0;
  endtask

  task automatic load_weights(input logic [31:0] base, input int step, input int stall_after,
                              input int start_at, output int t_last, output logic [WALL-1:0] wexp);
    bit ok;
    wexp   = '0;
    t_last = 0;
    for (int c = 0; c < COL; c++) begin
      wexp[c*CWID +: CWID] = wcol(base, step, c);
      i_w_valid = 1'b1;
      i_w_data  = wcol(base, step, c);
      if (c == start_at) i_start = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
        @(negedge clk);
        if (o_w_ready) ok = 1'b1;
        else tick();
      end
      if (!ok) fail("w_ready_timeout");
      t_last = cyc;
      if (c == COL - 1) begin
        wq_cyc.push_back(cyc + 1);
        wq_dat.push_back(wexp);
      end
      tick();
      i_w_valid = 1'b0;
      i_start   = 1'b0;
      if (c == stall_after) repeat (3) tick();
    end
    // A ninth beat offered during the strobe must not be taken.
    i_w_valid = 1'b1;
    @(negedge clk);
    chk("w_ready_in_strobe", WALL'(o_w_ready), '0);
    i_w_valid = 1'b0;
  endtask

  task automatic stream(input logic [31:0] base, input int step, input int mask, input int len,
                        input bit last_chk, output int t_last);
    bit              ok;
    int              v;
    fexp_t           e;
    logic [CWID-1:0] fv;
    v      = 0;
    t_last = 0;
    for (int k = 0; k < len; k++) begin
      if (mask[k]) begin
        fv        = fvec(base, step, v);
        i_f_valid = 1'b1;
        i_f_data  = fv;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
          @(negedge clk);
          if (o_f_ready) ok = 1'b1;
          else tick();
        end
        if (!ok) fail("f_ready_timeout");
        t_last = cyc;
        for (int r = 0; r < ROW; r++) begin
          e.cyc  = cyc + 1 + r;
          e.row  = r;
          e.data = fv[r*DW +: DW];
          fq.push_back(e);
        end
        v++;
        tick();
        i_f_valid = 1'b0;
      end else begin
        tick();
      end
    end
    if (last_chk) begin
      @(negedge clk);
      chk("f_ready_after_last", WALL'(o_f_ready), '0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  int              tl, tv;
  logic [WALL-1:0] wa, wb, wc, wd, we;

  initial begin
    rst       = 1'b1;
    i_start   = 1'b0;
    i_num_vec = '0;
    i_w_valid = 1'b0;
    i_w_data  = '0;
    i_f_valid = 1'b0;
    i_f_data  = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", WALL'(o_busy), '0);
    chk("rst_fmap_vld", WALL'(o_fmap_vld), '0);
    chk("rst_fmap", WALL'(o_fmap), '0);
    chk("rst_weight_col", o_weight_col, '0);
    chk("rst_ready_done", WALL'({o_w_ready, o_f_ready, o_weight_en, o_done}), '0);

    // Weight load with a 3-cycle stall, single vector skew, drain timing
    start_job(1);
    load_weights(32'h3F800000, 0, 3, -1, tl, wa);
    stream(32'h40000000, 1, 1, 1, 1'b1, tv);
    dq.push_back(tv + 1 + D);
    goto_cyc(tv + 8);
    chk("busy_in_drain", WALL'(o_busy), WALL'(1));
    goto_cyc(tv + 18);
    chk("busy_after_done", WALL'(o_busy), '0);
    chk("weight_hold_a", o_weight_col, wa);

    // Bubbles: valid pattern 1,0,1,1 with three vectors
    start_job(3);
    load_weights(32'h41000000, 32'h100, -1, -1, tl, wb);
    stream(32'h42000000, 32'h10, 4'b1101, 4, 1'b1, tv);
    dq.push_back(tv + 1 + D);
    goto_cyc(tv + 18);
    chk("busy_after_bubbles", WALL'(o_busy), '0);

    // Reset two cycles after the second accept of a four-vector job
    start_job(4);
    load_weights(32'h43000000, 32'h40, -1, -1, tl, wc);
    stream(32'h44000000, 32'h8, 3, 2, 1'b0, tv);
    rst = 1'b1;
    fq.delete();
    wq_cyc.delete();
    wq_dat.delete();
    dq.delete();
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", WALL'(o_busy), '0);
    chk("midrst_fmap_vld", WALL'(o_fmap_vld), '0);
    chk("midrst_fmap", WALL'(o_fmap), '0);
    chk("midrst_weight_col", o_weight_col, '0);
    chk("midrst_f_ready", WALL'(o_f_ready), '0);

    // Normal job after the reset
    start_job(2);
    load_weights(32'h45000000, 32'h11, -1, -1, tl, wd);
    stream(32'h46000000, 32'h3, 3, 2, 1'b1, tv);
    dq.push_back(tv + 1 + D);
    goto_cyc(tv + 18);
    chk("busy_after_job_d", WALL'(o_busy), '0);

    // Zero-vector job with a stray start during the weight load
    start_job(0);
    load_weights(32'h3F000000, 32'h20, -1, 2, tl, we);
    dq.push_back(tl + 2);
    goto_cyc(tl + 3);
    chk("busy_after_zero_job", WALL'(o_busy), '0);
    goto_cyc(tl + 15);
    chk("no_retrigger_busy", WALL'(o_busy), '0);
    chk("weight_hold_e", o_weight_col, we);

    repeat (3) tick();
    @(negedge clk);
    chk("scoreboard_empty", WALL'(fq.size() + wq_cyc.size() + dq.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_array_feeder.md
Name: pe_array_feeder

Overview:
Job sequencer that feeds the PE_fpu systolic array.
- Loads one weight column per handshake beat and presents the full weight set with a one-cycle load strobe.
- Streams feature-map vectors into the array's left edge, with per-row diagonal skew and per-row valid.
- Drains the array and signals job completion.
- Sits between the buffer/DMA side and the PE array, parametrised in data width, rows and columns.

Parameters:
DATA_WIDTH, 32, width of one FP32 word (passed bit-exact, no arithmetic)
NUMBER_PE_ROW, 9, PE rows; words per vector and number of skew lanes
NUMBER_PE_COL, 8, PE columns; weight beats per job
VEC_COUNT_W, 16, width of the per-job vector count

Ports:
i_clk  in  1  clock
i_rest  in  1  synchronous active-high reset
i_start  in  1  job start pulse; ignored unless IDLE
i_num_vec  in  VEC_COUNT_W  vectors in job; latched on accepted i_start
i_w_valid  in  1  weight beat valid
i_w_data  in  DATA_WIDTH*NUMBER_PE_ROW  one weight column (row r at [r*DW +: DW])
o_w_ready  out  1  weight beat accepted when valid&ready
i_f_valid  in  1  fmap vector valid
i_f_data  in  DATA_WIDTH*NUMBER_PE_ROW  one fmap vector (row r word at [r*DW +: DW])
o_f_ready  out  1  fmap vector accepted when valid&ready
o_weight_col  out  DATA_WIDTH*NUMBER_PE_ROW*NUMBER_PE_COL  stored weights (column c at [c*DW*ROW +: DW*ROW])
o_weight_en  out  1  one-cycle weight-load strobe to the array
o_fmap  out  DATA_WIDTH*NUMBER_PE_ROW  skewed fmap to the array's left edge
o_fmap_vld  out  NUMBER_PE_ROW  per-row valid; drives the array's left enables
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset (sync, any state including mid-job):
  - State goes to IDLE; all counters clear; skew registers and o_weight_col clear.
  - All outputs 0.
- FSM states: IDLE, LOAD_W, W_STROBE, STREAM, DRAIN, DONE.
  - IDLE: on i_start, latch i_num_vec, clear col_cnt, go to LOAD_W.
  - LOAD_W: o_w_ready=1. Each handshake writes i_w_data into column col_cnt and increments col_cnt (0..COL-1). i_w_valid low stalls with no side effects. The handshake at col_cnt=COL-1 goes to W_STROBE.
  - W_STROBE: o_weight_en=1 for exactly this one cycle. Next state is STREAM if num_vec>0, else DONE.
  - STREAM: o_f_ready=1 while vec_cnt<num_vec. An accepted vector enters skew stage 0 with valid=1; a cycle with no acceptance enters valid=0 and data 0, so bubbles are preserved. After the handshake with vec_cnt=num_vec-1, go to DRAIN.
  - DRAIN: runs for exactly D = NUMBER_PE_ROW-1+NUMBER_PE_COL cycles. Only zeros with valid=0 enter the skew, then go to DONE.
  - DONE: o_done=1 for one cycle, then IDLE.
- o_weight_col holds its value after DONE until the next load or reset.
- Skew: a vector accepted at cycle T drives o_fmap row r with o_fmap_vld[r]=1 at cycle T+1+r, for exactly one cycle per vector.
  - Lane r is a (r+1)-deep register chain.
  - The lane-0 output is registered, so latency is 1.
- i_start while o_busy=1 is ignored. Handshake inputs outside their state are ignored (ready=0).
- Counter widths: col_cnt uses $clog2(COL) bits; drain counter uses $clog2(D+1) bits. vec_cnt compare is VEC_COUNT_W wide; a count of 2^VEC_COUNT_W-1 is legal.

Decomposition:
- Shared package pe_array_pkg: state enum type, DATA_WIDTH/NUMBER_PE_ROW/NUMBER_PE_COL defaults, and a localparam function computing the drain length D.
- One sub-module, skew_delay_line: parametrised DEPTH and WIDTH shift register carrying {valid,data}, with synchronous clear. Instantiate it per row via generate, with DEPTH=r+1.

Test Plan:
- Reset mid-stream: start with num_vec=4, assert i_rest for 2 cycles after the 2nd accept -> o_busy=0, o_fmap_vld=0, o_fmap=0, o_weight_col=0 the cycle after reset. A new job then runs normally.
- Weight load with stalls: 8 beats, column c words = 32'h3F800000+c, i_w_valid dropped for 3 cycles after beat 4 -> exactly 8 handshakes. o_weight_en high exactly once, the cycle after beat 8. Column c slice matches.
- Skew timing: num_vec=1, vector row r = 32'h40000000+r accepted at T -> o_fmap_vld[r]=1 only at T+1+r, with o_fmap row r = 32'h40000000+r. All other valid bits are 0.
- Bubbles: num_vec=3, i_f_valid pattern 1,0,1,1 -> each lane shows valid 1,0,1,1 shifted by r+1. o_f_ready drops the cycle after the 3rd accept.
- Drain/done: last accept at T -> DRAIN cycles T+1..T+16. o_done=1 only at T+17, o_busy=0 at T+18. Row 8 last valid is at T+9.
- num_vec=0, plus i_start pulsed during LOAD_W -> after the weight strobe, o_done the next cycle. No o_fmap_vld asserted. The extra start does not retrigger a job.
